// File: rtl/flow_pkg.sv
// Shared types and constants for the flow-control library (branch/merge elements).
package flow_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OUT_HI = 2'd1,
        OUT_LO = 2'd2,
        IN_LO  = 2'd3
    } merge_state_t;

    // Branch tags: the equal path is branch 0, the not-equal path is branch 1.
    localparam logic SEL_EQ  = 1'b0;
    localparam logic SEL_NEQ = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant, purely combinational.
// On a tie the branch that was not served last wins.
module rr_arb2 (
    input  logic       req0,
    input  logic       req1,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (req0 && (!req1 || last)) begin
            gnt = 2'b01;
        end else if (req1) begin
            gnt = 2'b10;
        end
    end

endmodule

// File: rtl/branch_merge.sv
// Two-into-one four-phase merge with round-robin tie-break; all outputs registered.
//
//   state  | meaning
//   IDLE   | sampling requests, grant on any request
//   OUT_HI | out_req high, waiting for out_ack high
//   OUT_LO | out_req low, waiting for out_ack low
//   IN_LO  | ack to granted branch high, waiting for its req low
module branch_merge
    import flow_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             req0,
    input  logic [WIDTH-1:0] d0,
    output logic             ack0,
    input  logic             req1,
    input  logic [WIDTH-1:0] d1,
    output logic             ack1,
    output logic             out_req,
    output logic [WIDTH-1:0] out_d,
    output logic             out_sel,
    input  logic             out_ack
);

    merge_state_t     state, state_nxt;
    logic             last, last_nxt;
    logic             out_req_nxt, ack0_nxt, ack1_nxt, out_sel_nxt;
    logic [WIDTH-1:0] out_d_nxt;
    logic [1:0]       gnt;
    logic             req_g;

    rr_arb2 u_arb (
        .req0 (req0),
        .req1 (req1),
        .last (last),
        .gnt  (gnt)
    );

    // out_sel doubles as the granted-branch register for the whole transfer.
    assign req_g = (out_sel == SEL_NEQ) ? req1 : req0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            out_req <= 1'b0;
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            out_d   <= '0;
            out_sel <= SEL_EQ;
            last    <= 1'b1;
        end else begin
            state   <= state_nxt;
            out_req <= out_req_nxt;
            ack0    <= ack0_nxt;
            ack1    <= ack1_nxt;
            out_d   <= out_d_nxt;
            out_sel <= out_sel_nxt;
            last    <= last_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (gnt != 2'b00) state_nxt = OUT_HI;
            OUT_HI:  if (out_ack)      state_nxt = OUT_LO;
            OUT_LO:  if (!out_ack)     state_nxt = IN_LO;
            IN_LO:   if (!req_g)       state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        out_req_nxt = out_req;
        ack0_nxt    = ack0;
        ack1_nxt    = ack1;
        out_d_nxt   = out_d;
        out_sel_nxt = out_sel;
        last_nxt    = last;
        case (state)
            IDLE: begin
                if (gnt != 2'b00) begin
                    out_req_nxt = 1'b1;
                    out_sel_nxt = gnt[1] ? SEL_NEQ : SEL_EQ;
                    out_d_nxt   = gnt[1] ? d1 : d0;
                end
            end
            OUT_HI: begin
                if (out_ack) out_req_nxt = 1'b0;
            end
            OUT_LO: begin
                if (!out_ack) begin
                    ack0_nxt = (out_sel == SEL_EQ);
                    ack1_nxt = (out_sel == SEL_NEQ);
                end
            end
            IN_LO: begin
                if (!req_g) begin
                    ack0_nxt = 1'b0;
                    ack1_nxt = 1'b0;
                    last_nxt = out_sel;
                end
            end
            default: begin
                out_req_nxt = 1'b0;
                ack0_nxt    = 1'b0;
                ack1_nxt    = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_branch_merge.sv
// Self-checking bench for branch_merge: vector table plus hand-written corner sequences.
module tb_branch_merge;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         req0 = 1'b0, req1 = 1'b0, out_ack = 1'b0;
    logic [W-1:0] d0 = '0, d1 = '0;
    logic         ack0, ack1, out_req, out_sel;
    logic [W-1:0] out_d;

    branch_merge #(.WIDTH(W)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .req0    (req0),
        .d0      (d0),
        .ack0    (ack0),
        .req1    (req1),
        .d1      (d1),
        .ack1    (ack1),
        .out_req (out_req),
        .out_d   (out_d),
        .out_sel (out_sel),
        .out_ack (out_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         sel;
        logic [W-1:0] d;
    } xfer_t;

    typedef struct {
        logic         r0;
        logic [W-1:0] v0;
        logic         r1;
        logic [W-1:0] v1;
        int           ds_wait;
        logic         s_a;
        logic [W-1:0] d_a;
        logic         two;
        logic         s_b;
        logic [W-1:0] d_b;
    } vec_t;

    int           checks = 0;
    int           errors = 0;
    xfer_t        sb[$];
    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];
    bit           src_en = 1'b0;
    bit           ds_en = 1'b0;
    int           ds_wait = 0;
    int           ds_cnt = 0;
    xfer_t        exp_x;
    logic         p_req = 1'b0, p_a0 = 1'b0, p_a1 = 1'b0;
    vec_t         vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((sb.size() > 0 || q0.size() > 0 || q1.size() > 0 || req0 || req1 ||
                ack0 || ack1 || out_req || out_ack) && n < budget) begin
            step(1);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0 after %0d cycles", sb.size(), budget);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 rstn = 1'b0;
        step(1);
        rstn = 1'b1;
        step(1);
    endtask

    // Upstream sources and downstream sink, each answering one cycle after what they see.
    initial forever begin
        @(posedge clk);
        #1;
        if (ds_en) begin
            if (out_req && !out_ack) begin
                if (ds_cnt >= ds_wait) begin
                    out_ack = 1'b1;
                    ds_cnt  = 0;
                end else begin
                    ds_cnt++;
                end
            end else if (!out_req && out_ack) begin
                out_ack = 1'b0;
            end
        end
        if (src_en) begin
            if (req0 && ack0) req0 = 1'b0;
            else if (!req0 && !ack0 && q0.size() > 0) begin
                d0   = q0.pop_front();
                req0 = 1'b1;
            end
            if (req1 && ack1) req1 = 1'b0;
            else if (!req1 && !ack1 && q1.size() > 0) begin
                d1   = q1.pop_front();
                req1 = 1'b1;
            end
        end
    end

    // Scoreboard: every out_req rise pops the next expected transfer.
    initial forever begin
        @(posedge clk);
        #2;
        if (out_req && !p_req) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_xfer: got sel %0d data %0h expected none", out_sel, out_d);
            end else begin
                exp_x = sb.pop_front();
                check("xfer_sel", 32'(out_sel), 32'(exp_x.sel));
                check("xfer_data", 32'(out_d), 32'(exp_x.d));
            end
        end
        if (ack0 && !p_a0) begin
            check("ack0_branch", 32'(out_sel), 32'd0);
            check("ack0_order", 32'({out_req, out_ack}), 32'd0);
        end
        if (ack1 && !p_a1) begin
            check("ack1_branch", 32'(out_sel), 32'd1);
            check("ack1_order", 32'({out_req, out_ack}), 32'd0);
        end
        p_req = out_req;
        p_a0  = ack0;
        p_a1  = ack1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{1'b1, 8'h11, 1'b1, 8'h22, 0, 1'b0, 8'h11, 1'b1, 1'b1, 8'h22};
        vecs[1] = '{1'b1, 8'h77, 1'b0, 8'h00, 0, 1'b0, 8'h77, 1'b0, 1'b0, 8'h00};
        vecs[2] = '{1'b0, 8'h00, 1'b1, 8'h5A, 1, 1'b1, 8'h5A, 1'b0, 1'b0, 8'h00};
        vecs[3] = '{1'b1, 8'h0F, 1'b0, 8'h00, 2, 1'b0, 8'h0F, 1'b0, 1'b0, 8'h00};
        vecs[4] = '{1'b1, 8'h88, 1'b1, 8'h99, 0, 1'b1, 8'h99, 1'b1, 1'b0, 8'h88};
        vecs[5] = '{1'b1, 8'hC3, 1'b1, 8'h3C, 3, 1'b1, 8'h3C, 1'b1, 1'b0, 8'hC3};
        vecs[6] = '{1'b0, 8'h00, 1'b1, 8'hE1, 0, 1'b1, 8'hE1, 1'b0, 1'b0, 8'h00};

        // Reset values, before any clock edge.
        #2;
        check("rst_out_req", 32'(out_req), 32'd0);
        check("rst_ack0", 32'(ack0), 32'd0);
        check("rst_ack1", 32'(ack1), 32'd0);
        check("rst_out_d", 32'(out_d), 32'd0);
        check("rst_out_sel", 32'(out_sel), 32'd0);
        step(2);
        rstn = 1'b1;
        step(1);

        // Spurious out_ack in IDLE.
        out_ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1);
            check("spurious_ack_outputs", 32'({out_req, ack0, ack1, out_sel, out_d}), 32'd0);
        end
        out_ack = 1'b0;
        step(1);

        // Single request on branch 0, downstream acks after 2 cycles.
        d0 = 8'hA5;
        req0 = 1'b1;
        sb.push_back('{1'b0, 8'hA5});
        step(1);
        check("single_latency", 32'(out_req), 32'd1);
        check("single_data", 32'(out_d), 32'hA5);
        step(2);
        check("single_hold", 32'(out_req), 32'd1);
        out_ack = 1'b1;
        step(1);
        check("single_out_req_fall", 32'(out_req), 32'd0);
        step(1);
        check("single_ack0_waits", 32'(ack0), 32'd0);
        out_ack = 1'b0;
        step(1);
        check("single_ack0_rise", 32'(ack0), 32'd1);
        step(1);
        check("single_ack0_hold", 32'(ack0), 32'd1);
        req0 = 1'b0;
        step(1);
        check("single_ack0_fall", 32'(ack0), 32'd0);

        // Data change after grant is ignored.
        d0 = 8'h3C;
        req0 = 1'b1;
        sb.push_back('{1'b0, 8'h3C});
        step(1);
        d0 = 8'hFF;
        step(1);
        check("stable_mid_out_hi", 32'(out_d), 32'h3C);
        out_ack = 1'b1;
        step(1);
        out_ack = 1'b0;
        step(1);
        check("stable_ack0", 32'(ack0), 32'd1);
        check("stable_in_lo", 32'(out_d), 32'h3C);
        req0 = 1'b0;
        step(2);
        check("stable_after_xfer", 32'({out_sel, out_d}), 32'h03C);
        d0 = 8'h00;

        // Vector table with automatic neighbours; reset first so the first tie follows reset.
        do_reset();
        src_en = 1'b1;
        ds_en  = 1'b1;
        for (int i = 0; i < 7; i++) begin
            ds_wait = vecs[i].ds_wait;
            sb.push_back('{vecs[i].s_a, vecs[i].d_a});
            if (vecs[i].two) sb.push_back('{vecs[i].s_b, vecs[i].d_b});
            if (vecs[i].r0) q0.push_back(vecs[i].v0);
            if (vecs[i].r1) q1.push_back(vecs[i].v1);
            wait_idle(80);
        end
        src_en = 1'b0;
        ds_en  = 1'b0;
        step(1);

        // Reset asserted while in OUT_LO.
        d1 = 8'h5A;
        req1 = 1'b1;
        sb.push_back('{1'b1, 8'h5A});
        step(1);
        check("midrst_grant", 32'({out_req, out_sel}), 32'd3);
        out_ack = 1'b1;
        step(1);
        check("midrst_out_lo", 32'(out_req), 32'd0);
        #2 rstn = 1'b0;
        #1;
        check("midrst_out_req", 32'(out_req), 32'd0);
        check("midrst_ack0", 32'(ack0), 32'd0);
        check("midrst_ack1", 32'(ack1), 32'd0);
        check("midrst_out_d", 32'(out_d), 32'd0);
        check("midrst_out_sel", 32'(out_sel), 32'd0);
        req1 = 1'b0;
        out_ack = 1'b0;
        step(1);
        rstn = 1'b1;
        step(1);
        src_en  = 1'b1;
        ds_en   = 1'b1;
        ds_wait = 0;
        sb.push_back('{1'b1, 8'h6B});
        q1.push_back(8'h6B);
        wait_idle(40);

        // Fairness: both branches requesting continuously.
        sb.push_back('{1'b0, 8'hA0});
        sb.push_back('{1'b1, 8'hB0});
        sb.push_back('{1'b0, 8'hA1});
        sb.push_back('{1'b1, 8'hB1});
        sb.push_back('{1'b0, 8'hA2});
        sb.push_back('{1'b1, 8'hB2});
        q0.push_back(8'hA0);
        q0.push_back(8'hA1);
        q0.push_back(8'hA2);
        q1.push_back(8'hB0);
        q1.push_back(8'hB1);
        q1.push_back(8'hB2);
        wait_idle(150);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
